// File: rtl/mem_control_pkg.sv
// mem_control_pkg: shared types for the memory controller.
//   state_t : FSM state encoding, exported on the interface for debug/handshake.
//   op_t    : kind of access recorded when a request leaves IDLE.
package mem_control_pkg;

  typedef enum logic [2:0] {
    StInit     = 3'd0,
    StIdle     = 3'd1,
    StReadReq  = 3'd2,
    StWriteReq = 3'd3,
    StRead     = 3'd4,
    StWrite    = 3'd5,
    StWait     = 3'd6
  } state_t;

  typedef enum logic [1:0] {
    OpNone      = 2'd0,
    OpReadData  = 2'd1,
    OpReadInstr = 2'd2,
    OpWrite     = 2'd3
  } op_t;

endpackage

// File: rtl/mem_control_if.sv
// mem_control_if: CPU-side requests and bus-side data of the memory controller.
//   master : the core/bus environment (drives requests and bus read data)
//   slave  : mem_control (drives state, latched address and data returns)
// Signals:
//   address_in, data_in_CPU, data_in_BUS, data_en, instr_en, bus_full,
//   memWrite, memRead                      -> controller inputs
//   state, address_out, data_out_CPU, data_out_BUS, data_out_INSTR
//                                          -> controller outputs (registered)
interface mem_control_if;
  import mem_control_pkg::*;

  logic [31:0] address_in;
  logic [31:0] data_in_CPU;
  logic [31:0] data_in_BUS;
  logic        data_en;
  logic        instr_en;
  logic        bus_full;
  logic        memWrite;
  logic        memRead;
  state_t      state;
  logic [31:0] address_out;
  logic [31:0] data_out_CPU;
  logic [31:0] data_out_BUS;
  logic [31:0] data_out_INSTR;

  modport master (
    output address_in, data_in_CPU, data_in_BUS, data_en, instr_en, bus_full,
           memWrite, memRead,
    input  state, address_out, data_out_CPU, data_out_BUS, data_out_INSTR
  );

  modport slave (
    input  address_in, data_in_CPU, data_in_BUS, data_en, instr_en, bus_full,
           memWrite, memRead,
    output state, address_out, data_out_CPU, data_out_BUS, data_out_INSTR
  );

endinterface

// File: rtl/mem_control.sv
// mem_control: arbitrates CPU loads/stores and instruction fetches onto one
// shared memory bus. Each access goes request -> (wait while bus_full) ->
// read/write -> idle. Priority in IDLE is store > load > fetch.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-low reset (aborts any access in flight)
//   bus : mem_control_if.slave, request inputs and registered outputs
module mem_control
  import mem_control_pkg::*;
(
  input logic           clk,
  input logic           rst,
  mem_control_if.slave  bus
);

  state_t      r_state;
  op_t         r_op;
  logic [31:0] r_addr;
  logic [31:0] r_wbuf;
  logic [31:0] r_dcpu;
  logic [31:0] r_dbus;
  logic [31:0] r_dinstr;

  state_t      w_state_next;
  op_t         w_op_next;

  // Next-state logic; w_op_next is only meaningful on the IDLE exit edge.
  always_comb begin
    w_state_next = r_state;
    w_op_next    = r_op;
    case (r_state)
      StInit: w_state_next = StIdle;
      StIdle: begin
        if (bus.data_en && bus.memWrite) begin
          w_state_next = StWriteReq;
          w_op_next    = OpWrite;
        end else if (bus.data_en && bus.memRead) begin
          w_state_next = StReadReq;
          w_op_next    = OpReadData;
        end else if (bus.instr_en) begin
          w_state_next = StReadReq;
          w_op_next    = OpReadInstr;
        end
      end
      StReadReq:  w_state_next = bus.bus_full ? StWait : StRead;
      StWriteReq: w_state_next = bus.bus_full ? StWait : StWrite;
      StWait: begin
        if (!bus.bus_full) begin
          w_state_next = (r_op == OpWrite) ? StWrite : StRead;
        end
      end
      StRead:  w_state_next = StIdle;
      StWrite: w_state_next = StIdle;
      default: w_state_next = StInit;  // unused encoding 7
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= StInit;
      r_op     <= OpNone;
      r_addr   <= '0;
      r_wbuf   <= '0;
      r_dcpu   <= '0;
      r_dbus   <= '0;
      r_dinstr <= '0;
    end else begin
      r_state <= w_state_next;
      // Address/store data are sampled only when a request leaves IDLE.
      if (r_state == StIdle && w_state_next != StIdle) begin
        r_op   <= w_op_next;
        r_addr <= bus.address_in;
        r_wbuf <= bus.data_in_CPU;
      end
      if (w_state_next == StWrite) begin
        r_dbus <= r_wbuf;
      end
      // Read data is captured on the edge that leaves Read.
      if (r_state == StRead) begin
        if (r_op == OpReadInstr) begin
          r_dinstr <= bus.data_in_BUS;
        end else begin
          r_dcpu <= bus.data_in_BUS;
        end
      end
    end
  end

  assign bus.state          = r_state;
  assign bus.address_out    = r_addr;
  assign bus.data_out_CPU   = r_dcpu;
  assign bus.data_out_BUS   = r_dbus;
  assign bus.data_out_INSTR = r_dinstr;

endmodule

// File: tb/tb_mem_control.sv
// tb_mem_control: directed checks from hand-computed values, then randomized
// traffic compared every cycle against a transaction-level model.
module tb_mem_control;

  logic clk;
  logic rst;
  int   total;
  int   bad;
  bit   checking;

  mem_control_if u_if ();

  mem_control u_dut (
    .clk (clk),
    .rst (rst),
    .bus (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Transaction-level model: one access descriptor, no state encoding kept.
  bit          m_started;
  bit          m_pending;
  bit          m_granted;
  bit          m_is_write;
  bit          m_is_instr;
  int unsigned m_age;
  logic [31:0] m_addr, m_wdata, m_cpu, m_bus, m_instr;

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      m_started  <= 1'b0;
      m_pending  <= 1'b0;
      m_granted  <= 1'b0;
      m_is_write <= 1'b0;
      m_is_instr <= 1'b0;
      m_age      <= 0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_cpu      <= '0;
      m_bus      <= '0;
      m_instr    <= '0;
    end else if (!m_started) begin
      m_started <= 1'b1;
    end else if (!m_pending) begin
      if ((u_if.data_en && (u_if.memWrite || u_if.memRead)) || u_if.instr_en) begin
        m_pending  <= 1'b1;
        m_granted  <= 1'b0;
        m_age      <= 0;
        m_is_write <= u_if.data_en && u_if.memWrite;
        m_is_instr <= !(u_if.data_en && (u_if.memWrite || u_if.memRead));
        m_addr     <= u_if.address_in;
        m_wdata    <= u_if.data_in_CPU;
      end
    end else if (!m_granted) begin
      m_age <= m_age + 1;
      if (!u_if.bus_full) begin
        m_granted <= 1'b1;
        if (m_is_write) m_bus <= m_wdata;
      end
    end else begin
      m_pending <= 1'b0;
      if (!m_is_write) begin
        if (m_is_instr) m_instr <= u_if.data_in_BUS;
        else            m_cpu   <= u_if.data_in_BUS;
      end
    end
  end

  function automatic logic [31:0] exp_state();
    if (!m_started) return 32'd0;
    if (!m_pending) return 32'd1;
    if (!m_granted) return (m_age == 0) ? (m_is_write ? 32'd3 : 32'd2) : 32'd6;
    return m_is_write ? 32'd5 : 32'd4;
  endfunction

  always @(negedge clk) begin
    if (checking) begin
      check("cyc_state", 32'(u_if.state), exp_state());
      check("cyc_addr", u_if.address_out, m_addr);
      check("cyc_cpu", u_if.data_out_CPU, m_cpu);
      check("cyc_bus", u_if.data_out_BUS, m_bus);
      check("cyc_instr", u_if.data_out_INSTR, m_instr);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    u_if.data_en  = 1'b0;
    u_if.instr_en = 1'b0;
    u_if.memWrite = 1'b0;
    u_if.memRead  = 1'b0;
    u_if.bus_full = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_state"}, 32'(u_if.state), 32'd0);
    check({tag, "_addr"}, u_if.address_out, 32'd0);
    check({tag, "_cpu"}, u_if.data_out_CPU, 32'd0);
    check({tag, "_bus"}, u_if.data_out_BUS, 32'd0);
    check({tag, "_instr"}, u_if.data_out_INSTR, 32'd0);
  endtask

  initial begin
    total    = 0;
    bad      = 0;
    checking = 1'b0;
    idle_inputs();
    u_if.address_in  = '0;
    u_if.data_in_CPU = '0;
    u_if.data_in_BUS = '0;
    rst = 1'b1;
    #1 rst = 1'b0;
    checking = 1'b1;

    // Reset held for two cycles, then INIT -> IDLE on first edge.
    tick();
    tick();
    check_all_zero("rst");
    rst = 1'b1;
    tick();
    check("rel_state", 32'(u_if.state), 32'd1);

    // Data load, bus free.
    u_if.address_in  = 32'h100;
    u_if.data_en     = 1'b1;
    u_if.memRead     = 1'b1;
    u_if.data_in_BUS = 32'hDEADBEEF;
    tick();
    check("ld_state1", 32'(u_if.state), 32'd2);
    check("ld_addr", u_if.address_out, 32'h100);
    idle_inputs();
    tick();
    check("ld_state2", 32'(u_if.state), 32'd4);
    tick();
    check("ld_state3", 32'(u_if.state), 32'd1);
    check("ld_cpu", u_if.data_out_CPU, 32'hDEADBEEF);
    check("ld_instr", u_if.data_out_INSTR, 32'd0);

    // Store, bus free.
    u_if.address_in  = 32'h200;
    u_if.data_in_CPU = 32'h12345678;
    u_if.data_en     = 1'b1;
    u_if.memWrite    = 1'b1;
    tick();
    check("st_state1", 32'(u_if.state), 32'd3);
    idle_inputs();
    tick();
    check("st_state2", 32'(u_if.state), 32'd5);
    check("st_bus", u_if.data_out_BUS, 32'h12345678);
    check("st_addr", u_if.address_out, 32'h200);
    tick();
    check("st_state3", 32'(u_if.state), 32'd1);

    // Instruction fetch.
    u_if.address_in  = 32'h40;
    u_if.instr_en    = 1'b1;
    u_if.data_in_BUS = 32'h00000013;
    tick();
    idle_inputs();
    tick();
    tick();
    check("if_state", 32'(u_if.state), 32'd1);
    check("if_instr", u_if.data_out_INSTR, 32'h13);
    check("if_cpu", u_if.data_out_CPU, 32'hDEADBEEF);
    check("if_addr", u_if.address_out, 32'h40);

    // Stall: bus_full for three cycles; address_in changes during Wait.
    u_if.address_in = 32'h300;
    u_if.data_en    = 1'b1;
    u_if.memRead    = 1'b1;
    tick();
    check("sl_req", 32'(u_if.state), 32'd2);
    u_if.data_en    = 1'b0;
    u_if.memRead    = 1'b0;
    u_if.bus_full   = 1'b1;
    u_if.address_in = 32'hFFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("sl_wait", 32'(u_if.state), 32'd6);
    end
    check("sl_addr_hold", u_if.address_out, 32'h300);
    u_if.bus_full    = 1'b0;
    u_if.data_in_BUS = 32'hCAFEF00D;
    tick();
    check("sl_read", 32'(u_if.state), 32'd4);
    tick();
    check("sl_idle", 32'(u_if.state), 32'd1);
    check("sl_cpu", u_if.data_out_CPU, 32'hCAFEF00D);

    // Priority: store wins over fetch and load.
    u_if.address_in  = 32'h500;
    u_if.data_in_CPU = 32'hA5A5A5A5;
    u_if.instr_en    = 1'b1;
    u_if.data_en     = 1'b1;
    u_if.memWrite    = 1'b1;
    u_if.memRead     = 1'b1;
    tick();
    check("pr_state", 32'(u_if.state), 32'd3);
    idle_inputs();
    tick();
    tick();
    check("pr_done", 32'(u_if.state), 32'd1);

    // Abort: reset asserted while in Wait.
    u_if.data_en = 1'b1;
    u_if.memRead = 1'b1;
    tick();
    u_if.data_en  = 1'b0;
    u_if.memRead  = 1'b0;
    u_if.bus_full = 1'b1;
    tick();
    check("ab_wait", 32'(u_if.state), 32'd6);
    #2 rst = 1'b0;
    #1;
    check_all_zero("ab");
    tick();
    rst = 1'b1;
    u_if.bus_full = 1'b0;
    tick();
    check("ab_rel", 32'(u_if.state), 32'd1);

    // Randomized traffic, with occasional asynchronous resets.
    for (int n = 0; n < 3000; n++) begin
      tick();
      if ($urandom_range(0, 399) == 0) begin
        #2 rst = 1'b0;
        #4 rst = 1'b1;
      end
      u_if.data_en     = ($urandom_range(0, 1) == 1);
      u_if.memWrite    = ($urandom_range(0, 2) == 0);
      u_if.memRead     = ($urandom_range(0, 1) == 1);
      u_if.instr_en    = ($urandom_range(0, 2) == 0);
      u_if.bus_full    = ($urandom_range(0, 9) < 3);
      u_if.address_in  = $urandom;
      u_if.data_in_CPU = $urandom;
      u_if.data_in_BUS = $urandom;
    end
    tick();
    checking = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_control.md
# mem_control

Memory controller that arbitrates CPU data accesses and instruction fetches onto a single shared memory bus. It sits between the RV32I core (load/store unit and fetch stage) and the bus interface. It sequences each access through a request phase, stalls while the bus reports full, and returns read data to either the data path or the instruction path. All outputs are registered, and the FSM state is exported for debug and handshake.

## Interface
Parameters:
- none (all widths fixed at 32 bits)

Ports:
- clk  in  1  system clock; rising-edge triggered
- rst  in  1  asynchronous, active-low reset
- address_in  in  32  CPU access address (data or instruction)
- data_in_CPU  in  32  store data from CPU
- data_in_BUS  in  32  read data returned by bus
- data_en  in  1  data-memory access request qualifier
- instr_en  in  1  instruction fetch request
- bus_full  in  1  bus busy; stalls the access
- memWrite  in  1  store request (valid with data_en)
- memRead  in  1  load request (valid with data_en)
- state  out  3  current FSM state (state_t encoding)
- address_out  out  32  latched bus address
- data_out_CPU  out  32  load result to CPU
- data_out_BUS  out  32  store data to bus
- data_out_INSTR  out  32  fetched instruction

## Operation
State encoding (state_t, 3 bits):
- INIT=0, IDLE=1, Read_Request=2, Write_Request=3, Read=4, Write=5, Wait=6
- Encoding 7 is unused and decodes to INIT.

Transitions, evaluated at each rising edge:
- INIT -> IDLE unconditionally.
- IDLE:
  - data_en & memWrite -> Write_Request.
  - Else data_en & memRead -> Read_Request, op = DATA.
  - Else instr_en -> Read_Request, op = INSTR.
  - Else stay in IDLE.
  - Priority is store > load > fetch. memRead & memWrite together is treated as a store.
- On leaving IDLE for a request state, the controller latches address_in into address_out, latches data_in_CPU into an internal write buffer, and records the op (READ_DATA, READ_INSTR or WRITE).
- Read_Request / Write_Request: if bus_full, go to Wait. Otherwise go to Read or Write respectively.
- Wait: hold while bus_full. When bus_full deasserts, go to Read or Write according to the recorded op.
- Read:
  - Capture data_in_BUS into data_out_CPU (READ_DATA) or data_out_INSTR (READ_INSTR). The other output holds its value.
  - Then go to IDLE.
- Write: data_out_BUS is loaded from the write buffer on entry to Write. Then go to IDLE.
- Request inputs are ignored outside IDLE. Address and data are sampled only at the IDLE exit edge.
- Outputs that are not being updated hold their last value.

## Timing
- Reset (rst=0, asynchronous): state=INIT and all 32-bit outputs = 0, including address_out. The write buffer and op register are cleared. Reset asserted mid-access aborts the access immediately.
- First rising edge after reset release: INIT -> IDLE.
- Load with bus free: request sampled at edge k (-> Read_Request). Edge k+1 -> Read. Edge k+2 captures data_in_BUS and returns to IDLE. Read data is valid after edge k+2, a 3-cycle latency.
- Store with bus free: edge k -> Write_Request; edge k+1 -> Write with data_out_BUS valid; edge k+2 -> IDLE.
- Each cycle bus_full is high in a request state or Wait adds one cycle of latency.
- data_in_BUS must be valid during the Read-state cycle. It is sampled at the edge that leaves Read.
- Back-to-back accesses: a new request can be sampled on the edge after returning to IDLE. Minimum access period is 3 cycles.

## Structure
- Shared package mem_control_pkg holds the state_t enum (values above) and the op encoding enum.
- Single flat module with no sub-modules:
  - one always_ff block (async reset) for state, op and datapath registers;
  - one always_comb block for next-state logic.

## Test plan
- Reset: hold rst=0 for 2 cycles -> state=INIT and all outputs 0. First edge after release gives state=IDLE.
- Data load: address_in=0x100, data_en=1, memRead=1, bus_full=0, data_in_BUS=0xDEADBEEF.
  - After 1 edge: state=Read_Request, address_out=0x100.
  - After 2 edges: state=Read.
  - After 3 edges: state=IDLE, data_out_CPU=0xDEADBEEF, data_out_INSTR unchanged.
- Store: address_in=0x200, data_in_CPU=0x12345678, data_en=1, memWrite=1.
  - States go Write_Request -> Write (data_out_BUS=0x12345678, address_out=0x200) -> IDLE.
- Fetch: instr_en=1, data_en=0, address_in=0x40, data_in_BUS=0x00000013 -> after 3 edges, data_out_INSTR=0x13 and data_out_CPU unchanged.
- Stall: load request with bus_full=1 for 3 cycles -> Read_Request, then Wait x3. After bus_full drops -> Read, then IDLE with correct data. address_in changes during Wait must not alter address_out.
- Priority and abort:
  - instr_en=1 together with data_en=1, memWrite=1 -> Write_Request taken.
  - Asserting rst in Wait -> immediate INIT with outputs 0.
